// File: rtl/cmd_frame_tx.sv
// Purpose: serialises a latched {speed, dir, mode} command as a UART-like frame on tx_o.
// Latency: start bit appears the cycle after acceptance; each bit lasts bit_div clocks.
// Backpressure: cmd_ready high only in IDLE; inputs are ignored while a frame is in flight.
// Option: define CMD_FRAME_TX_PARITY_EN to append an even-parity bit before the stop bit.
module cmd_frame_tx #(
  parameter int cmd_l         = 4,
  parameter int bit_div       = 8,
  parameter int def_speed_cmd = 5,
  parameter int def_dir_cmd   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [cmd_l-1:0] speed_cmd_i,
  input  logic [cmd_l-1:0] dir_cmd_i,
  input  logic [1:0]       mode,
  output logic             tx_o,
  output logic             busy_o,
  output logic [7:0]       frame_cnt_o
);

  localparam int DATA_BITS = 2 * cmd_l + 2;
  localparam int TMR_W     = (bit_div > 2) ? $clog2(bit_div) : 1;
  localparam int IDX_W     = $clog2(DATA_BITS);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(bit_div - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef CMD_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [TMR_W-1:0]     bit_tmr;
  logic [IDX_W-1:0]     bit_idx;
  logic [cmd_l-1:0]     speed_q;
  logic [cmd_l-1:0]     dir_q;
  logic [1:0]           mode_q;
  logic [DATA_BITS-1:0] frame_bits;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 bit_end;

  // Payload in transmit order: bit 0 goes out first (speed LSB first, then dir, then mode).
  assign frame_bits = {mode_q, dir_q, speed_q};
  assign idx_nxt    = bit_idx + 1'b1;
  assign bit_end    = (bit_tmr == TMR_LAST);

  // Frame sequencer: all outputs registered so they change together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_o        <= 1'b1;
      cmd_ready   <= 1'b1;
      busy_o      <= 1'b0;
      frame_cnt_o <= 8'd0;
      bit_tmr     <= '0;
      bit_idx     <= '0;
      speed_q     <= cmd_l'(def_speed_cmd);
      dir_q       <= cmd_l'(def_dir_cmd);
      mode_q      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            speed_q   <= speed_cmd_i;
            dir_q     <= dir_cmd_i;
            mode_q    <= mode;
            state     <= START;
            tx_o      <= 1'b0;
            cmd_ready <= 1'b0;
            busy_o    <= 1'b1;
            bit_tmr   <= '0;
            bit_idx   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_tmr <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_o    <= frame_bits[0];
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_tmr <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef CMD_FRAME_TX_PARITY_EN
              state <= PARITY;
              tx_o  <= ^frame_bits;
`else
              state <= STOP;
              tx_o  <= 1'b1;
`endif
            end else begin
              bit_idx <= idx_nxt;
              tx_o    <= frame_bits[idx_nxt];
            end
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
`ifdef CMD_FRAME_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            bit_tmr <= '0;
            state   <= STOP;
            tx_o    <= 1'b1;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
`endif
        STOP: begin
          tx_o <= 1'b1;
          if (bit_end) begin
            bit_tmr     <= '0;
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy_o      <= 1'b0;
            frame_cnt_o <= frame_cnt_o + 8'd1;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          tx_o      <= 1'b1;
          cmd_ready <= 1'b1;
          busy_o    <= 1'b0;
          bit_tmr   <= '0;
        end
      endcase
    end
  end

endmodule
